// File: rtl/bongo_hit_detector.sv
// Two-pad bongo hit detector: synchronizes each pad, debounces it, stretches
// the hit into a fixed-length level, then locks out until the pad is released.
module bongo_hit_channel #(
  parameter int DEB_CYC  = 500000,
  parameter int HOLD_CYC = 50000,
  parameter int LOCK_CYC = 2500000,
  parameter int CNT_W    = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       s,
  output logic       bongo_hit,
  output logic       hit_pulse,
  output logic [7:0] hit_cnt
);

  typedef enum logic [2:0] {IDLE, DEBOUNCE, HIT, LOCKOUT, WAIT_REL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               pulse_q, pulse_d;
  logic [7:0]         hit_cnt_q, hit_cnt_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hit_cnt_d = hit_cnt_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = DEBOUNCE;
          cnt_d   = CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEB_CYC)) begin
          state_d = HIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIT: begin
        if (cnt_q == CNT_W'(HOLD_CYC)) begin
          state_d = LOCKOUT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCKOUT: begin
        if (cnt_q == CNT_W'(LOCK_CYC)) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (!s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    // Outputs are decoded from the next state so they are registered with it.
    hit_d   = (state_d == HIT);
    pulse_d = (state_d == HIT) && (state_q != HIT);
    if (pulse_d) hit_cnt_d = hit_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      pulse_q   <= 1'b0;
      hit_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      pulse_q   <= pulse_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign bongo_hit = hit_q;
  assign hit_pulse = pulse_q;
  assign hit_cnt   = hit_cnt_q;

endmodule

module bongo_hit_detector #(
  parameter int DEB_CYC  = 500000,
  parameter int HOLD_CYC = 50000,
  parameter int LOCK_CYC = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] pad,
  output logic [1:0] bongo_hit,
  output logic [1:0] hit_pulse,
  output logic [7:0] hit_cnt_l,
  output logic [7:0] hit_cnt_r
);

  localparam int MAX_DH  = (DEB_CYC > HOLD_CYC) ? DEB_CYC : HOLD_CYC;
  localparam int MAX_CYC = (MAX_DH > LOCK_CYC) ? MAX_DH : LOCK_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [7:0] hit_cnt [2];

  always_comb begin
    sync1_d = pad;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    bongo_hit_channel #(
      .DEB_CYC  (DEB_CYC),
      .HOLD_CYC (HOLD_CYC),
      .LOCK_CYC (LOCK_CYC),
      .CNT_W    (CNT_W)
    ) u_channel (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .s         (sync2_q[ch]),
      .bongo_hit (bongo_hit[ch]),
      .hit_pulse (hit_pulse[ch]),
      .hit_cnt   (hit_cnt[ch])
    );
  end

  assign hit_cnt_l = hit_cnt[0];
  assign hit_cnt_r = hit_cnt[1];

endmodule

// File: tb/tb_bongo_hit_detector.sv
// Directed bench for bongo_hit_detector with DEB_CYC=4, HOLD_CYC=3, LOCK_CYC=5.
module tb_bongo_hit_detector;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] pad;
  logic [1:0] bongo_hit;
  logic [1:0] hit_pulse;
  logic [7:0] hit_cnt_l;
  logic [7:0] hit_cnt_r;

  int n_cmp  = 0;
  int n_fail = 0;

  bongo_hit_detector #(
    .DEB_CYC  (4),
    .HOLD_CYC (3),
    .LOCK_CYC (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pad       (pad),
    .bongo_hit (bongo_hit),
    .hit_pulse (hit_pulse),
    .hit_cnt_l (hit_cnt_l),
    .hit_cnt_r (hit_cnt_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  typedef struct {
    int         rep;
    logic [1:0] pad;
    logic [1:0] hit;
    logic [1:0] pulse;
    logic [7:0] cl;
    logic [7:0] cr;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read 1 unit after the next.
  task automatic step(input logic e, input logic [1:0] p);
    en  = e;
    pad = p;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [1:0] p);
    @(negedge clk);
    rst = 1'b0;
    pad = p;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int hits;
    int row;

    // Clean left press, then a 3-cycle glitch on the right pad.
    tbl[0] = '{6,  2'b01, 2'b00, 2'b00, 8'd0, 8'd0};
    tbl[1] = '{1,  2'b01, 2'b01, 2'b01, 8'd1, 8'd0};
    tbl[2] = '{2,  2'b01, 2'b01, 2'b00, 8'd1, 8'd0};
    tbl[3] = '{11, 2'b01, 2'b00, 2'b00, 8'd1, 8'd0};
    tbl[4] = '{4,  2'b00, 2'b00, 2'b00, 8'd1, 8'd0};
    tbl[5] = '{3,  2'b10, 2'b00, 2'b00, 8'd1, 8'd0};
    tbl[6] = '{5,  2'b00, 2'b00, 2'b00, 8'd1, 8'd0};

    rst = 1'b0;
    en  = 1'b1;
    pad = 2'b11;
    #1;
    check("rst_t0", {bongo_hit, hit_pulse, hit_cnt_l, hit_cnt_r}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b11);
      check("rst_hold", {bongo_hit, hit_pulse, hit_cnt_l, hit_cnt_r}, 32'h0);
    end
    apply_reset(2'b00);

    row = 0;
    for (int v = 0; v < 7; v++) begin
      for (int r = 0; r < tbl[v].rep; r++) begin
        step(1'b1, tbl[v].pad);
        check($sformatf("tbl_row%0d", row), {bongo_hit, hit_pulse, hit_cnt_l, hit_cnt_r},
              {12'h0, tbl[v].hit, tbl[v].pulse, tbl[v].cl, tbl[v].cr});
        row++;
      end
    end

    // Held pad: one hit only, then a fresh hit after release and re-press.
    apply_reset(2'b00);
    step(1'b1, 2'b00);
    check("rst_clear", {bongo_hit, hit_pulse, hit_cnt_l, hit_cnt_r}, 32'h0);
    hits = 0;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 2'b01);
      if (hit_pulse[0]) hits++;
      if (i == 6) check("held_latency", bongo_hit, 2'b01);
    end
    check("held_one_hit", hits, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 2'b00);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 2'b01);
      if (hit_pulse[0]) hits++;
    end
    check("repress_hit", hits, 1);
    check("repress_cnt_l", hit_cnt_l, 8'd2);

    // Simultaneous press on both pads.
    for (int i = 0; i < 20; i++) step(1'b1, 2'b00);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 2'b11);
      if (i == 5) check("simul_early", bongo_hit, 2'b00);
      if (i == 6) check("simul_hit", {bongo_hit, hit_pulse, hit_cnt_l, hit_cnt_r},
                        {12'h0, 2'b11, 2'b11, 8'd3, 8'd1});
    end

    // Asynchronous reset while both channels are in HIT.
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", {bongo_hit, hit_pulse, hit_cnt_l, hit_cnt_r}, 32'h0);

    // Reset released with the left pad already high, then 256 hits to wrap.
    apply_reset(2'b01);
    hits = 0;
    for (int h = 0; h < 256; h++) begin
      for (int i = 0; i < 17; i++) begin
        step(1'b1, (i < 7) ? 2'b01 : 2'b00);
        if (hit_pulse[0]) hits++;
        if (h == 0 && i == 5) check("rel_no_early_hit", bongo_hit, 2'b00);
        if (h == 0 && i == 6) check("rel_first_hit", bongo_hit, 2'b01);
      end
      if (h == 254) check("cnt_255", hit_cnt_l, 8'd255);
    end
    check("wrap_hits", hits, 256);
    check("wrap_cnt_l", hit_cnt_l, 8'd0);
    check("wrap_cnt_r", hit_cnt_r, 8'd0);

    // Enable dropped mid-HIT, held off, then restored with the pad still high.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 2'b01);
      if (i == 6) check("en_hit", {bongo_hit, hit_cnt_l}, {2'b01, 8'd1});
    end
    step(1'b0, 2'b01);
    check("en_drop", {bongo_hit, hit_pulse, hit_cnt_l}, {2'b00, 2'b00, 8'd1});
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'b01);
      if (hit_pulse[0] || bongo_hit[0]) hits++;
    end
    check("en_off_quiet", hits, 0);
    check("en_off_cnt", hit_cnt_l, 8'd1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 2'b01);
      if (i == 3) check("en_back_early", bongo_hit, 2'b00);
      if (i == 4) check("en_back_hit", {bongo_hit, hit_pulse, hit_cnt_l}, {2'b01, 2'b01, 8'd2});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
